// File: rtl/key_event.sv
// Debounced key level to one-cycle press/release/long/repeat strobes on Clk,
// with a local synchronizer, free-running tick divider and hold-time FSM.
module key_event #(
    parameter int unsigned TICK_DIV     = 500000,
    parameter int unsigned LONG_TICKS   = 100,
    parameter int unsigned REPEAT_TICKS = 20
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Key_xi,
    output logic       Press_xo,
    output logic       Release_xo,
    output logic       Long_xo,
    output logic       Repeat_xo,
    output logic       Held_xo,
    output logic [7:0] Count_xo
);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        LONG
    } state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic [TW-1:0] tcnt;
    logic [15:0]   hcnt;
    logic [15:0]   hcnt_inc;
    logic          tick;
    logic          press_edge;
    logic          release_edge;

    assign tick         = (tcnt == TW'(TICK_DIV - 1));
    assign press_edge   = s2 & ~s3;
    assign release_edge = ~s2 & s3;
    assign hcnt_inc     = hcnt + 16'd1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Key_xi;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Release is tested before tick so it always wins over a threshold tick.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            hcnt       <= '0;
            Press_xo   <= 1'b0;
            Release_xo <= 1'b0;
            Long_xo    <= 1'b0;
            Repeat_xo  <= 1'b0;
            Held_xo    <= 1'b0;
            Count_xo   <= '0;
        end else begin
            Press_xo   <= 1'b0;
            Release_xo <= 1'b0;
            Long_xo    <= 1'b0;
            Repeat_xo  <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_edge) begin
                        state    <= PRESS;
                        hcnt     <= '0;
                        Press_xo <= 1'b1;
                        Held_xo  <= 1'b1;
                        Count_xo <= Count_xo + 8'd1;
                    end
                end
                PRESS: begin
                    if (release_edge) begin
                        state      <= IDLE;
                        hcnt       <= '0;
                        Release_xo <= 1'b1;
                        Held_xo    <= 1'b0;
                    end else if (tick) begin
                        if (hcnt_inc == 16'(LONG_TICKS)) begin
                            state   <= LONG;
                            hcnt    <= '0;
                            Long_xo <= 1'b1;
                        end else begin
                            hcnt <= hcnt_inc;
                        end
                    end
                end
                LONG: begin
                    if (release_edge) begin
                        state      <= IDLE;
                        hcnt       <= '0;
                        Release_xo <= 1'b1;
                        Held_xo    <= 1'b0;
                    end else if (tick) begin
                        if (hcnt_inc == 16'(REPEAT_TICKS)) begin
                            hcnt      <= '0;
                            Repeat_xo <= 1'b1;
                        end else begin
                            hcnt <= hcnt_inc;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    hcnt    <= '0;
                    Held_xo <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_event.sv
// Randomized scoreboard bench for key_event: a closed-form event model predicts
// every strobe from the sampled key history and tick-edge arithmetic.
module tb_key_event;
    localparam int D    = 4;
    localparam int L    = 3;
    localparam int R    = 2;
    localparam int HIST = 16384;

    logic       Clk;
    logic       Rst_n;
    logic       Key_xi;
    logic       Press_xo, Release_xo, Long_xo, Repeat_xo, Held_xo;
    logic [7:0] Count_xo;

    key_event #(.TICK_DIV(D), .LONG_TICKS(L), .REPEAT_TICKS(R)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Key_xi(Key_xi),
        .Press_xo(Press_xo), .Release_xo(Release_xo), .Long_xo(Long_xo),
        .Repeat_xo(Repeat_xo), .Held_xo(Held_xo), .Count_xo(Count_xo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int en;
        int kind;   // 0 press, 1 release, 2 long, 3 repeat
        int cnt;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;
    int  n = 0;
    bit  keyhist [0:HIST-1];
    bit  m_held = 0;
    int  m_count = 0;
    int  m_press_en = 0;
    int  mon_press = 0;
    int  mon_longs = 0;
    int  mon_last_press_en = -1;
    int  mon_last_rel_en = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, n);
        end
    endtask

    // Reference model: edge n counts posedges since reset release; ticks land on multiples of D.
    always @(posedge Clk) begin : model
        bit d, p;
        int t;
        if (!Rst_n) begin
            n = 0;
            m_held = 0;
            m_count = 0;
            keyhist[0] = 0;
            q.delete();
        end else begin
            n++;
            if (n < HIST) keyhist[n] = Key_xi;
            d = (n >= 2) ? keyhist[n-2] : 1'b0;
            p = (n >= 3) ? keyhist[n-3] : 1'b0;
            if (!m_held && d && !p) begin
                m_held = 1;
                m_press_en = n;
                m_count = (m_count + 1) % 256;
                q.push_back('{n, 0, m_count});
            end else if (m_held && !d && p) begin
                m_held = 0;
                q.push_back('{n, 1, m_count});
            end else if (m_held && (n % D == 0)) begin
                t = n / D - m_press_en / D;
                if (t == L) q.push_back('{n, 2, m_count});
                else if (t > L && ((t - L) % R == 0)) q.push_back('{n, 3, m_count});
            end
        end
    end

    always @(negedge Clk) begin : monitor
        int  kind, npulse;
        ev_t e;
        if (Rst_n) begin
            while (q.size() > 0 && q[0].en < n) begin
                e = q.pop_front();
                chk("missed_event_kind", -1, e.kind);
            end
            npulse = int'(Press_xo) + int'(Release_xo) + int'(Long_xo) + int'(Repeat_xo);
            if (npulse > 0) begin
                chk("pulse_exclusive", npulse, 1);
                kind = Press_xo ? 0 : Release_xo ? 1 : Long_xo ? 2 : 3;
                if (Press_xo) begin
                    mon_press++;
                    mon_last_press_en = n;
                end
                if (Long_xo) mon_longs++;
                if (Release_xo) mon_last_rel_en = n;
                if (q.size() == 0) begin
                    chk("unexpected_pulse_kind", kind, -1);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_edge", n, e.en);
                    if (kind == 0) chk("press_count", int'(Count_xo), e.cnt);
                end
            end
            chk("held", int'(Held_xo), int'(m_held));
            chk("count", int'(Count_xo), m_count);
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge Clk);
        #1;
    endtask

    task automatic wait_held(input bit v, input int budget, input string name);
        int c;
        c = 0;
        while (Held_xo !== v && c < budget) begin
            cycles(1);
            c++;
        end
        chk(name, int'(Held_xo), int'(v));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_press"}, int'(Press_xo), 0);
        chk({tag, "_release"}, int'(Release_xo), 0);
        chk({tag, "_long"}, int'(Long_xo), 0);
        chk({tag, "_repeat"}, int'(Repeat_xo), 0);
        chk({tag, "_held"}, int'(Held_xo), 0);
        chk({tag, "_count"}, int'(Count_xo), 0);
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        #1 Rst_n = 1'b0;
        cycles(3);
        Rst_n = 1'b1;
    endtask

    initial begin : stim
        int longs0, base, pe, tt;
        Rst_n = 1'b0;
        Key_xi = 1'b0;
        cycles(3);
        Rst_n = 1'b1;
        check_all_zero("reset");
        cycles(50);

        // Short press of 5 cycles.
        @(negedge Clk); Key_xi = 1'b1;
        cycles(5);
        Key_xi = 1'b0;
        cycles(12);
        chk("short_press_count", int'(Count_xo), 1);

        // Long hold of 40 cycles: long once, then repeats.
        longs0 = mon_longs;
        Key_xi = 1'b1;
        cycles(40);
        Key_xi = 1'b0;
        cycles(12);
        chk("hold_long_once", mon_longs - longs0, 1);

        // Release edge lands exactly on the long-threshold tick.
        longs0 = mon_longs;
        Key_xi = 1'b1;
        wait_held(1'b1, 20, "coinc_press_timeout");
        pe = mon_last_press_en;
        tt = (pe / D + 1) * D + (L - 1) * D;
        while (n < tt - 3) cycles(1);
        Key_xi = 1'b0;
        cycles(8);
        chk("coinc_release_edge", mon_last_rel_en, tt);
        chk("coinc_no_long", mon_longs - longs0, 0);

        // Randomized presses and gaps.
        for (int i = 0; i < 30; i++) begin
            Key_xi = 1'b1;
            cycles($urandom_range(1, 45));
            Key_xi = 1'b0;
            cycles($urandom_range(1, 12));
        end
        cycles(10);

        // 256 short presses from reset: counter wraps to 0.
        reset_dut();
        base = mon_press;
        for (int i = 0; i < 256; i++) begin
            Key_xi = 1'b1;
            cycles(3);
            Key_xi = 1'b0;
            cycles(3);
        end
        cycles(6);
        chk("wrap_count", int'(Count_xo), 0);
        chk("wrap_presses", mon_press - base, 256);

        // Reset asserted while in LONG with the key still held.
        longs0 = mon_longs;
        Key_xi = 1'b1;
        begin
            int c;
            c = 0;
            while (mon_longs == longs0 && c < 40) begin
                cycles(1);
                c++;
            end
        end
        chk("rst_long_reached", mon_longs - longs0, 1);
        chk("rst_pre_held", int'(Held_xo), 1);
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        mon_last_press_en = -1;
        cycles(3);
        Rst_n = 1'b1;
        cycles(6);
        chk("post_rst_press_edge", mon_last_press_en, 3);
        chk("post_rst_count", int'(Count_xo), 1);
        Key_xi = 1'b0;
        cycles(10);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event.md
# key_event

Converts the clean, debounced key level into system-clock-domain key events: single-cycle press and release pulses, a long-press pulse, and auto-repeat pulses while held. It sits directly downstream of the key debouncer, which produces a stable level on its slow 100 Hz domain, and feeds the instruction-fetch/step control logic with one-cycle strobes on `Clk`. The block contains its own synchronizer, a free-running tick divider, a hold-time counter and a three-state FSM.

## Interface
- `TICK_DIV`, default 500000: `Clk` cycles per hold-timing tick (10 ms at 50 MHz). Must be ≥ 2.
- `LONG_TICKS`, default 100: ticks held in PRESS before `Long_xo` fires. Must be ≥ 1.
- `REPEAT_TICKS`, default 20: ticks between `Repeat_xo` pulses in LONG. Must be ≥ 1.
- `Clk`  input  1  system clock; the only clock.
- `Rst_n`  input  1  asynchronous, active-low reset.
- `Key_xi`  input  1  debounced key level, 1 = pressed; asynchronous to `Clk`.
- `Press_xo`  output  1  one-cycle pulse on press.
- `Release_xo`  output  1  one-cycle pulse on release.
- `Long_xo`  output  1  one-cycle pulse once per press after `LONG_TICKS`.
- `Repeat_xo`  output  1  one-cycle pulse every `REPEAT_TICKS` in LONG.
- `Held_xo`  output  1  level: key currently pressed (synchronized).
- `Count_xo`  output  8  number of presses since reset, modulo 256.

## Operation
- Synchronizer: `s1 <= Key_xi`, `s2 <= s1`, `s3 <= s2`. The press edge is `s2 & ~s3`; the release edge is `~s2 & s3`.
- Tick divider: `tcnt` counts 0..`TICK_DIV`-1 and wraps. `tick` = (`tcnt` == `TICK_DIV`-1). It is free-running and never cleared except by reset.
- FSM states: IDLE, PRESS, LONG. Hold counter `hcnt` is 16 bits.
  - IDLE, press edge: go to PRESS, `hcnt` <= 0, pulse `Press_xo`, `Count_xo` += 1 (255 wraps to 0).
  - PRESS, `tick`: `hcnt` += 1. When the incremented value equals `LONG_TICKS`, pulse `Long_xo`, go to LONG, `hcnt` <= 0.
  - LONG, `tick`: `hcnt` += 1. When the incremented value equals `REPEAT_TICKS`, pulse `Repeat_xo`, `hcnt` <= 0, stay in LONG.
  - PRESS or LONG, release edge: pulse `Release_xo`, go to IDLE, `hcnt` <= 0.
- `Held_xo` = 1 in PRESS and LONG, 0 in IDLE. It is registered with the FSM state.
- Simultaneous events:
  - Release edge and threshold `tick` in the same cycle: release wins; no `Long_xo`/`Repeat_xo`.
  - Press edge and `tick` in the same cycle: the tick is not counted.
- Press, Release, Long and Repeat pulses are mutually exclusive in any cycle.
- An edge in an unexpected state (press edge in PRESS/LONG, release edge in IDLE) cannot occur from `s2`/`s3`. If it does, it is ignored.

## Timing
- Reset (async assert, sync release): all outputs 0; `s1..s3`, `tcnt`, `hcnt` = 0; state IDLE.
- Key latency: `Key_xi` rising, first sampled high at edge k, gives `Press_xo` = 1 for exactly the cycle after edge k+2. Release latency is identical.
- Every output is a register; there is no combinational path from input to output.
- Long-press latency from the `Press_xo` cycle: between (`LONG_TICKS`-1)·`TICK_DIV`+1 and `LONG_TICKS`·`TICK_DIV` cycles. The jitter is from the free-running tick phase.
- Repeat spacing is exactly `REPEAT_TICKS`·`TICK_DIV` cycles after `Long_xo` and between consecutive repeats.
- Reset mid-press: outputs clear immediately. If the key is still high after reset release, `s3` = 0 causes a fresh `Press_xo` 3 cycles later and `Count_xo` becomes 1.

## Test plan
- Params `TICK_DIV`=4, `LONG_TICKS`=3, `REPEAT_TICKS`=2. Hold reset, then release with `Key_xi`=0. Required: all outputs 0 and no pulses for 50 cycles.
- Raise `Key_xi` for 5 cycles. Required:
  - `Press_xo` fires once, 3 cycles after the rise, and `Count_xo` = 1.
  - `Release_xo` fires once, 3 cycles after the fall.
  - `Held_xo` is high for 5 cycles.
  - No `Long_xo`.
- Hold `Key_xi` for 40 cycles. Required:
  - `Long_xo` fires once, 9–12 cycles after `Press_xo`.
  - `Repeat_xo` fires every 8 cycles thereafter until release.
  - `Release_xo` fires, then `Held_xo` = 0.
- Release timed so the release edge coincides with the threshold tick. Required: `Release_xo` only, no `Long_xo`.
- Apply 256 short presses. Required: `Count_xo` wraps to 0 and `Press_xo` pulses 256 times.
- Assert `Rst_n` while in LONG with the key held, then release reset. Required:
  - Outputs go to 0 asynchronously.
  - `Press_xo` fires 3 cycles after reset release and `Count_xo` = 1.
